// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port arbiter in front of mem_system:
// FSM state encoding, port identifiers and the default starvation limit.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int STARVE_LIMIT_DEF = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data ports plus the next value of the
// saturating fetch-starvation counter.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       i_req,
  input  logic       d_req,
  input  logic       idle,
  input  logic       arb_en,
  input  logic [1:0] starve_cnt,
  output logic       winner,
  output logic [1:0] starve_next
);

  logic starved;

  assign starved = int'(starve_cnt) >= STARVE_LIMIT;

  always_comb begin
    winner      = PORT_I;
    starve_next = starve_cnt;

    if (d_req && !(i_req && starved)) begin
      winner = PORT_D;
    end

    // The counter only moves on a real grant, except that an absent fetch
    // request in IDLE always clears it.
    if (idle && !i_req) begin
      starve_next = 2'd0;
    end else if (arb_en) begin
      if (winner == PORT_I) begin
        starve_next = 2'd0;
      end else if (i_req && starve_cnt != 2'd3) begin
        starve_next = starve_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for mem_system: data port has priority, fetch is protected
// against starvation; one transaction in flight, done routed to its owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  output logic        i_hit,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        d_hit,
  output logic [15:0] mem_Addr,
  output logic [15:0] mem_DataIn,
  output logic        mem_Rd,
  output logic        mem_Wr,
  input  logic [15:0] mem_DataOut,
  input  logic        mem_Done,
  input  logic        mem_Stall,
  input  logic        mem_CacheHit
);

  arb_state_t  state, state_next;
  logic        gnt_d, wr_q;
  logic [15:0] addr_q, wdata_q;
  logic [1:0]  starve_cnt, starve_next;
  logic        idle, arb_en, winner;

  assign idle   = (state == ARB_IDLE);
  assign arb_en = idle && (i_req || d_req) && !mem_Stall;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .idle       (idle),
    .arb_en     (arb_en),
    .starve_cnt (starve_cnt),
    .winner     (winner),
    .starve_next(starve_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the winner's request so clients may change inputs while BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 2'd0;
      gnt_d      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
    end else begin
      starve_cnt <= starve_next;
      if (arb_en) begin
        gnt_d   <= winner;
        wr_q    <= (winner == PORT_D) && d_wr;
        addr_q  <= (winner == PORT_D) ? {d_addr[15:1], 1'b0} : {i_addr[15:1], 1'b0};
        wdata_q <= (winner == PORT_D) ? d_wdata : 16'h0000;
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_Addr   = 16'h0000;
    mem_DataIn = 16'h0000;
    mem_Rd     = 1'b0;
    mem_Wr     = 1'b0;
    i_done     = 1'b0;
    i_rdata    = 16'h0000;
    i_hit      = 1'b0;
    d_done     = 1'b0;
    d_rdata    = 16'h0000;
    d_hit      = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (arb_en) begin
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        mem_Addr   = addr_q;
        mem_DataIn = wdata_q;
        mem_Rd     = !wr_q;
        mem_Wr     = wr_q;
        if (mem_Done) begin
          state_next = ARB_IDLE;
          if (gnt_d == PORT_D) begin
            d_done  = 1'b1;
            d_rdata = mem_DataOut;
            d_hit   = mem_CacheHit;
          end else begin
            i_done  = 1'b1;
            i_rdata = mem_DataOut;
            i_hit   = mem_CacheHit;
          end
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural mem_system model
// and per-port scoreboards of expected read data.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_done, i_hit, d_done, d_hit;
  logic [15:0] i_rdata, d_rdata;
  logic [15:0] mem_Addr, mem_DataIn, mem_DataOut;
  logic        mem_Rd, mem_Wr, mem_Done, mem_Stall, mem_CacheHit;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_hit(i_hit),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_hit(d_hit),
    .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr),
    .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_Stall(mem_Stall),
    .mem_CacheHit(mem_CacheHit)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  req_t        pend_d[$], pend_i[$];
  req_t        cur_d, cur_i;
  bit          d_active, i_active;
  logic [15:0] exp_d[$], exp_i[$];
  bit          expw_d[$];
  byte         order[$];
  logic [15:0] ref_mem[logic [15:0]];
  logic [15:0] mem_arr[logic [15:0]];
  bit          cached[logic [15:0]];

  int          errors = 0, checks = 0, cyc = 0;
  int          last_start, d_issue, i_issue, i_done_cyc, ndone_d = 0, ndone_i = 0;
  bit          last_hit_i, last_hit_d;
  logic [15:0] last_rdata_i;
  bit          force_stall;

  bit          mbusy, mhit, mwr;
  int          mcnt;
  logic [15:0] maddr, mdata;

  function automatic logic [15:0] initVal(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] refRead(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : initVal(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit port_d, input bit wr, input logic [15:0] addr,
                               input logic [15:0] wdata);
    req_t r;
    r.wr = wr; r.addr = addr; r.wdata = wdata;
    if (port_d) pend_d.push_back(r);
    else begin r.wr = 1'b0; r.wdata = 16'h0; pend_i.push_back(r); end
  endtask

  // One clock: drive clients and memory model at negedge, sample 1 ns later.
  task automatic tick();
    logic [15:0] a, e;
    bit          w;
    @(negedge clk);
    cyc++;
    if (!d_active && pend_d.size() > 0) begin
      cur_d = pend_d.pop_front(); d_active = 1; d_issue = cyc;
      a = cur_d.addr & 16'hFFFE;
      if (cur_d.wr) ref_mem[a] = cur_d.wdata;
      exp_d.push_back(cur_d.wr ? 16'h0 : refRead(a));
      expw_d.push_back(cur_d.wr);
    end
    if (!i_active && pend_i.size() > 0) begin
      cur_i = pend_i.pop_front(); i_active = 1; i_issue = cyc;
      exp_i.push_back(refRead(cur_i.addr & 16'hFFFE));
    end
    d_req = d_active; d_wr = cur_d.wr; d_addr = cur_d.addr; d_wdata = cur_d.wdata;
    i_req = i_active; i_addr = cur_i.addr;

    mem_Done = 0; mem_CacheHit = 0; mem_DataOut = 16'h0;
    if (rst) mbusy = 0;
    else if (mbusy) begin
      mcnt--;
      if (mcnt == 0) begin
        mem_Done = 1; mem_CacheHit = mhit; mbusy = 0;
        if (mwr) mem_arr[maddr] = mdata;
        else mem_DataOut = mem_arr.exists(maddr) ? mem_arr[maddr] : initVal(maddr);
      end
    end else if (mem_Rd || mem_Wr) begin
      mbusy = 1; maddr = mem_Addr; mwr = mem_Wr; mdata = mem_DataIn;
      mhit = cached.exists(maddr); cached[maddr] = 1;
      mcnt = mhit ? 1 : 8; last_start = cyc;
    end
    mem_Stall = force_stall;

    #1;
    if (d_done || i_done) checkOutput("one_done", d_done & i_done, 0);
    if (mem_Done && !d_done) checkOutput("d_quiet", {d_rdata, 15'h0, d_hit}, 0);
    if (mem_Done && !i_done) checkOutput("i_quiet", {i_rdata, 15'h0, i_hit}, 0);
    if (d_done) begin
      checkOutput("d_owner", d_active, 1);
      if (d_active) begin
        e = exp_d.pop_front(); w = expw_d.pop_front();
        if (!w) checkOutput("d_rdata", d_rdata, e);
        checkOutput("d_hit", d_hit, mhit);
        checkOutput("d_lat", (cyc - last_start) <= (mhit ? 2 : 20), 1);
        d_active = 0; ndone_d++; last_hit_d = d_hit; order.push_back(8'h44);
      end
    end
    if (i_done) begin
      checkOutput("i_owner", i_active, 1);
      if (i_active) begin
        e = exp_i.pop_front();
        checkOutput("i_rdata", i_rdata, e);
        checkOutput("i_hit", i_hit, mhit);
        checkOutput("i_lat", (cyc - last_start) <= (mhit ? 2 : 20), 1);
        i_active = 0; ndone_i++; i_done_cyc = cyc; last_hit_i = i_hit;
        last_rdata_i = i_rdata; order.push_back(8'h49);
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int k = 0; k < budget && (d_active || i_active || pend_d.size() > 0 || pend_i.size() > 0); k++)
      tick();
    checkOutput(tag, pend_d.size() + pend_i.size() + int'(d_active) + int'(i_active), 0);
  endtask

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    string exp_order;
    int    nd, ni, pushes_d, pushes_i;
    rst = 1; force_stall = 0;
    i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    mem_DataOut = 0; mem_Done = 0; mem_Stall = 0; mem_CacheHit = 0;
    cur_d = '{0, 16'h0, 16'h0}; cur_i = '{0, 16'h0, 16'h0};

    repeat (3) tick();
    checkOutput("rst_mem", {mem_Rd, mem_Wr, mem_Addr, mem_DataIn}, 0);
    checkOutput("rst_done", {i_done, d_done, i_hit, d_hit}, 0);
    rst = 0;
    tick();
    checkOutput("post_rst", {mem_Rd, mem_Wr, mem_Addr, d_rdata}, 0);

    // Warm 0x6002 with a data write, then fetch it back as a hit.
    applyStimulus(1, 1, 16'h6002, 16'hBEEF);
    drain("warm_drain", 50);
    applyStimulus(0, 0, 16'h6002, 16'h0);
    drain("fetch_drain", 50);
    checkOutput("fetch_rd_start", last_start - i_issue, 1);
    checkOutput("fetch_done_lat", (i_done_cyc - i_issue) <= 3, 1);
    checkOutput("fetch_hit", last_hit_i, 1);
    checkOutput("fetch_beef", last_rdata_i, 16'hBEEF);

    nd = ndone_d;
    applyStimulus(1, 1, 16'h0010, 16'h1234);
    applyStimulus(1, 0, 16'h0010, 16'h0);
    drain("wr_rd_drain", 60);
    checkOutput("wr_rd_dones", ndone_d - nd, 2);
    checkOutput("rd_hit", last_hit_d, 1);

    // Both ports held busy: data wins twice, then the starved fetch.
    repeat (2) tick();
    order.delete();
    for (int k = 0; k < 4; k++) applyStimulus(1, k[0], 16'h0100 + 16'(k * 2), 16'h7700 + 16'(k));
    for (int k = 0; k < 2; k++) applyStimulus(0, 0, 16'h8040 + 16'(k * 2), 16'h0);
    drain("contend_drain", 200);
    exp_order = "DDIDDI";
    checkOutput("order_len", order.size(), 6);
    for (int k = 0; k < 6; k++) checkOutput($sformatf("order%0d", k), order[k], exp_order[k]);

    force_stall = 1;
    applyStimulus(1, 0, 16'h0010, 16'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("stall_hold", {mem_Rd, mem_Wr}, 0);
    end
    force_stall = 0;
    tick();
    tick();
    checkOutput("stall_issue", mem_Rd, 1);
    drain("stall_drain", 50);

    // Reset three cycles into a miss; the read is abandoned.
    nd = ndone_d;
    applyStimulus(1, 0, 16'hA000, 16'h0);
    tick();
    tick();
    checkOutput("a000_rd", mem_Rd, 1);
    tick();
    tick();
    rst = 1; d_active = 0; exp_d.delete(); expw_d.delete();
    tick();
    rst = 0;
    tick();
    checkOutput("midrst_mem", {mem_Rd, mem_Wr, mem_Addr, mem_DataIn}, 0);
    checkOutput("midrst_done", {d_done, d_rdata, i_done}, 0);
    repeat (10) tick();
    checkOutput("midrst_no_done", ndone_d - nd, 0);
    ni = ndone_i;
    applyStimulus(0, 0, 16'h0000, 16'h0);
    drain("post_rst_fetch", 50);
    checkOutput("post_rst_fetch_done", ndone_i - ni, 1);

    // Mixed random traffic over disjoint fetch and data regions.
    nd = ndone_d; ni = ndone_i; pushes_d = 0; pushes_i = 0;
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r[0]) begin
        applyStimulus(1, 1'($urandom_range(0, 1)), {8'h00, 8'($urandom_range(0, 255))},
                      16'($urandom));
        pushes_d++;
      end
      if (r[1]) begin
        applyStimulus(0, 0, {8'h80, 4'h0, 4'($urandom_range(0, 15))}, 16'h0);
        pushes_i++;
      end
      repeat ($urandom_range(1, 4)) tick();
    end
    drain("rand_drain", 20000);
    checkOutput("rand_d_count", ndone_d - nd, pushes_d);
    checkOutput("rand_i_count", ndone_i - ni, pushes_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
